// File: rtl/ihex_prog_loader.sv
// Intel HEX loader: 8N1 UART receiver plus record parser that drives the program-memory write port.
// 16-bit words are assembled little-endian, and each completed word produces a two-cycle write strobe.
module ihex_prog_loader #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [15:0] PROGDATA,
   output logic [15:0] PROGADD,
   output logic        prog_we,
   output logic        prog_clk,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int unsigned    DIV     = CLK_HZ / BAUD;
   localparam int unsigned    CW      = $clog2(DIV + 1);
   localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0]  HALF_M1 = CW'(DIV / 2 - 1);

   typedef enum logic [2:0] {
      U_WAIT_START, U_START, U_DATA, U_STOP, U_WAIT_HIGH
   } ustate_t;

   typedef enum logic [2:0] {
      P_IDLE, P_LEN, P_ADDR, P_TYPE, P_DATA, P_CSUM
   } pstate_t;

   // ---------------- UART receiver ----------------
   ustate_t       ustate, ustate_n;
   logic          rx_m, rx_s, rx_d;
   logic [CW-1:0] ucnt, ucnt_n;
   logic [2:0]    bitn, bitn_n;
   logic [7:0]    shreg, shreg_n;
   logic          byte_valid, frame_err;

   // Synchronizer flops reset to the idle level so reset release cannot fake a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m   <= 1'b1;
         rx_s   <= 1'b1;
         rx_d   <= 1'b1;
         ustate <= U_WAIT_START;
         ucnt   <= '0;
         bitn   <= '0;
         shreg  <= '0;
      end else begin
         rx_m   <= rx;
         rx_s   <= rx_m;
         rx_d   <= rx_s;
         ustate <= ustate_n;
         ucnt   <= ucnt_n;
         bitn   <= bitn_n;
         shreg  <= shreg_n;
      end
   end

   always_comb begin
      ustate_n   = ustate;
      ucnt_n     = ucnt + 1'b1;
      bitn_n     = bitn;
      shreg_n    = shreg;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (ustate)
         U_WAIT_START: begin
            ucnt_n = '0;
            if (rx_d && !rx_s) ustate_n = U_START;
         end
         U_START: begin
            if (ucnt == HALF_M1) begin
               ucnt_n   = '0;
               bitn_n   = '0;
               ustate_n = rx_s ? U_WAIT_START : U_DATA;
            end
         end
         U_DATA: begin
            if (ucnt == DIV_M1) begin
               ucnt_n  = '0;
               shreg_n = {rx_s, shreg[7:1]};
               bitn_n  = bitn + 3'd1;
               if (bitn == 3'd7) ustate_n = U_STOP;
            end
         end
         U_STOP: begin
            if (ucnt == DIV_M1) begin
               ucnt_n = '0;
               if (rx_s) begin
                  byte_valid = 1'b1;
                  ustate_n   = U_WAIT_START;
               end else begin
                  frame_err  = 1'b1;
                  ustate_n   = U_WAIT_HIGH;
               end
            end
         end
         U_WAIT_HIGH: begin
            ucnt_n = '0;
            if (rx_s) ustate_n = U_WAIT_START;
         end
         default: begin
            ucnt_n   = '0;
            ustate_n = U_WAIT_START;
         end
      endcase
   end

   // ---------------- record parser ----------------
   function automatic logic [4:0] hexval(input logic [7:0] c);
      logic [4:0] r;
      r = '0;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, c[3:0]};
      else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

   pstate_t     pstate, pstate_n;
   logic        busy_n;
   logic [7:0]  csum, csum_n, csum_sum;
   logic        have_nib, have_nib_n;
   logic [3:0]  hi_nib, hi_nib_n;
   logic [7:0]  len, len_n;
   logic [15:0] addr, addr_n;
   logic [7:0]  rtype, rtype_n;
   logic [7:0]  dcnt, dcnt_n, dcnt_inc;
   logic [7:0]  lo, lo_n;
   logic [15:0] waddr, waddr_n;
   logic        misalign, misalign_n;
   logic [4:0]  dv;
   logic [7:0]  bval;
   logic        wr_go, perr, pdone, we_q;
   logic [15:0] wr_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pstate   <= P_IDLE;
         busy     <= 1'b0;
         csum     <= '0;
         have_nib <= 1'b0;
         hi_nib   <= '0;
         len      <= '0;
         addr     <= '0;
         rtype    <= '0;
         dcnt     <= '0;
         lo       <= '0;
         waddr    <= '0;
         misalign <= 1'b0;
      end else begin
         pstate   <= pstate_n;
         busy     <= busy_n;
         csum     <= csum_n;
         have_nib <= have_nib_n;
         hi_nib   <= hi_nib_n;
         len      <= len_n;
         addr     <= addr_n;
         rtype    <= rtype_n;
         dcnt     <= dcnt_n;
         lo       <= lo_n;
         waddr    <= waddr_n;
         misalign <= misalign_n;
      end
   end

   always_comb begin
      pstate_n   = pstate;
      busy_n     = busy;
      csum_n     = csum;
      have_nib_n = have_nib;
      hi_nib_n   = hi_nib;
      len_n      = len;
      addr_n     = addr;
      rtype_n    = rtype;
      dcnt_n     = dcnt;
      lo_n       = lo;
      waddr_n    = waddr;
      misalign_n = misalign;
      wr_go      = 1'b0;
      wr_data    = '0;
      perr       = 1'b0;
      pdone      = 1'b0;
      dv         = hexval(shreg);
      bval       = {hi_nib, dv[3:0]};
      csum_sum   = csum + bval;
      dcnt_inc   = dcnt + 8'd1;
      if (byte_valid) begin
         if (pstate == P_IDLE) begin
            if (shreg == 8'h3A) begin
               pstate_n   = P_LEN;
               busy_n     = 1'b1;
               csum_n     = '0;
               have_nib_n = 1'b0;
            end
         end else if (!dv[4]) begin
            perr     = 1'b1;
            pstate_n = P_IDLE;
            busy_n   = 1'b0;
         end else if (!have_nib) begin
            hi_nib_n   = dv[3:0];
            have_nib_n = 1'b1;
         end else begin
            have_nib_n = 1'b0;
            csum_n     = csum_sum;
            case (pstate)
               P_LEN: begin
                  len_n    = bval;
                  dcnt_n   = '0;
                  pstate_n = P_ADDR;
               end
               P_ADDR: begin
                  if (!dcnt[0]) begin
                     addr_n[15:8] = bval;
                     dcnt_n       = 8'd1;
                  end else begin
                     addr_n[7:0]  = bval;
                     pstate_n     = P_TYPE;
                  end
               end
               P_TYPE: begin
                  rtype_n    = bval;
                  dcnt_n     = '0;
                  waddr_n    = {1'b0, addr[15:1]};
                  misalign_n = (bval == 8'h00) && addr[0];
                  perr       = (bval == 8'h00) && addr[0];
                  pstate_n   = (len == 8'h00) ? P_CSUM : P_DATA;
               end
               P_DATA: begin
                  dcnt_n = dcnt_inc;
                  // Even-position bytes are held as the low half; a trailing one is padded with 0xFF.
                  if (rtype == 8'h00 && !misalign) begin
                     if (!dcnt[0]) begin
                        lo_n = bval;
                        if (dcnt_inc == len) begin
                           wr_go   = 1'b1;
                           wr_data = {8'hFF, bval};
                        end
                     end else begin
                        wr_go   = 1'b1;
                        wr_data = {bval, lo};
                     end
                  end
                  if (wr_go) waddr_n = waddr + 16'd1;
                  if (dcnt_inc == len) pstate_n = P_CSUM;
               end
               P_CSUM: begin
                  pstate_n = P_IDLE;
                  busy_n   = 1'b0;
                  if (csum_sum != 8'h00) perr = 1'b1;
                  else if (rtype == 8'h01) pdone = 1'b1;
               end
               default: begin
                  pstate_n = P_IDLE;
                  busy_n   = 1'b0;
               end
            endcase
         end
      end
   end

   // ---------------- write strobe and status ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PROGADD  <= '0;
         PROGDATA <= '0;
         prog_we  <= 1'b0;
         prog_clk <= 1'b0;
         we_q     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (wr_go) begin
            PROGADD  <= waddr;
            PROGDATA <= wr_data;
         end
         we_q     <= wr_go;
         prog_we  <= wr_go | we_q;
         prog_clk <= we_q;
         done     <= done | pdone;
         err      <= err | perr | frame_err;
      end
   end

endmodule
